// File: rtl/seg_pkg.sv
// Shared display constants: blank pattern, BCD limit and the seven-segment
// table (bit order {dp,g,f,e,d,c,b,a}, active high).
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;

endpackage

// File: rtl/num_decoder.sv
// BCD digit to seven-segment pattern; non-decimal codes show blank.
module num_decoder
    import seg_pkg::*;
(
    input  logic [3:0] num,
    output logic [7:0] seg
);

    // Table lookup of the segment pattern
    always_comb begin
        seg = SEG_BLANK;
        case (num)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/strobe_gen.sv
// Free-running 0..DIV prescaler; tick is high for the cycle the count equals DIV.
module strobe_gen #(
    parameter int DIV = 9
) (
    input  logic clk,
    input  logic rstb,
    input  logic sclr,
    output logic tick
);

    localparam int          W     = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [W-1:0] DIV_W = W'(DIV);

    logic [W-1:0] cnt_r;

    // Prescaler count with synchronous restart
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_r <= '0;
        end else if (sclr) begin
            cnt_r <= '0;
        end else if (cnt_r == DIV_W) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign tick = (cnt_r == DIV_W);

endmodule

// File: rtl/seg_scan_counter.sv
// N-digit BCD up/down counter with load/clear, roll-over pulse and a
// multiplexed seven-segment scan driver (MSD scanned first).
module seg_scan_counter
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV      = 49999,
    parameter int COUNT_DIV     = 49999999,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    en,
    input  logic                    up,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    wrap,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic [7:0]              seg_data
);

    localparam int                    VW        = 4 * NUM_DIGITS;
    localparam int                    IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT_RST = NUM_DIGITS'(1) << (NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_RST   = ((BLANK_LEADING != 0) && (NUM_DIGITS > 1)) ? SEG_BLANK : SEG_0;

    function automatic logic [VW-1:0] bcd_saturate(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (v[4*k +: 4] > BCD_MAX) r[4*k +: 4] = BCD_MAX;
            else                       r[4*k +: 4] = v[4*k +: 4];
        end
        return r;
    endfunction

    // Returns {carry_out, sum}
    function automatic logic [VW:0] bcd_inc(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!c) begin
                r[4*k +: 4] = v[4*k +: 4];
            end else if (v[4*k +: 4] >= BCD_MAX) begin
                r[4*k +: 4] = 4'd0;
            end else begin
                r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                c           = 1'b0;
            end
        end
        return {c, r};
    endfunction

    // Returns {borrow_out, difference}
    function automatic logic [VW:0] bcd_dec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!b) begin
                r[4*k +: 4] = v[4*k +: 4];
            end else if (v[4*k +: 4] == 4'd0) begin
                r[4*k +: 4] = BCD_MAX;
            end else begin
                r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                b           = 1'b0;
            end
        end
        return {b, r};
    endfunction

    // A nibble blanks when it and all more-significant nibbles are zero; nibble 0 never does
    function automatic logic [NUM_DIGITS-1:0] leading_blank_mask(input logic [VW-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (v[4*k +: 4] == 4'd0);
            m[k]       = (BLANK_LEADING != 0) && (k != 0) && zero_above;
        end
        return m;
    endfunction

    logic [VW-1:0]         value_r;
    logic                  wrap_r;
    logic [NUM_DIGITS-1:0] digit_r;
    logic [7:0]            seg_r;
    logic [IW-1:0]         scan_idx_r;

    logic                  count_tick_s;
    logic                  scan_tick_s;
    logic [VW:0]           step_s;
    logic [NUM_DIGITS-1:0] blank_s;
    logic [IW-1:0]         idx_next_s;
    logic [3:0]            sel_nibble_s;
    logic                  sel_blank_s;
    logic [NUM_DIGITS-1:0] digit_next_s;
    logic [7:0]            dec_seg_s;
    logic [7:0]            seg_next_s;

    strobe_gen #(.DIV(COUNT_DIV)) u_count_strobe (
        .clk  (clk),
        .rstb (rstb),
        .sclr (clr),
        .tick (count_tick_s)
    );

    strobe_gen #(.DIV(SCAN_DIV)) u_scan_strobe (
        .clk  (clk),
        .rstb (rstb),
        .sclr (1'b0),
        .tick (scan_tick_s)
    );

    // Next counter value in the selected direction
    always_comb begin
        step_s = '0;
        if (up) begin
            step_s = bcd_inc(value_r);
        end else begin
            step_s = bcd_dec(value_r);
        end
    end

    // Counter register: clr > load > enabled count strobe
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            value_r <= '0;
            wrap_r  <= 1'b0;
        end else if (clr) begin
            value_r <= '0;
            wrap_r  <= 1'b0;
        end else if (load) begin
            value_r <= bcd_saturate(load_val);
            wrap_r  <= 1'b0;
        end else if (count_tick_s && en) begin
            value_r <= step_s[VW-1:0];
            wrap_r  <= step_s[VW];
        end else begin
            wrap_r  <= 1'b0;
        end
    end

    assign blank_s = leading_blank_mask(value_r);

    // Select the nibble, blank flag and digit enable for the next scan slot
    always_comb begin
        idx_next_s   = (scan_idx_r == IDX_LAST) ? '0 : scan_idx_r + 1'b1;
        sel_nibble_s = 4'd0;
        sel_blank_s  = 1'b0;
        digit_next_s = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(NUM_DIGITS - 1 - k) == idx_next_s) begin
                sel_nibble_s    = value_r[4*k +: 4];
                sel_blank_s     = blank_s[k];
                digit_next_s[k] = 1'b1;
            end else begin
                digit_next_s[k] = 1'b0;
            end
        end
    end

    num_decoder u_dec (
        .num (sel_nibble_s),
        .seg (dec_seg_s)
    );

    assign seg_next_s = sel_blank_s ? SEG_BLANK : dec_seg_s;

    // Scan index, digit enable and segment bus update together so they never skew
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            scan_idx_r <= '0;
            digit_r    <= DIGIT_RST;
            seg_r      <= SEG_RST;
        end else if (scan_tick_s) begin
            scan_idx_r <= idx_next_s;
            digit_r    <= digit_next_s;
            seg_r      <= seg_next_s;
        end else begin
            scan_idx_r <= scan_idx_r;
        end
    end

    assign value    = value_r;
    assign wrap     = wrap_r;
    assign digit    = digit_r;
    assign seg_data = seg_r;

endmodule

// File: tb/tb_seg_scan_counter.sv
// Randomised self-checking bench: a decimal/integer reference model runs in
// lock-step with two DUT instances (leading-zero blanking on and off).
module tb_seg_scan_counter;

    localparam int ND        = 4;
    localparam int SCAN_DIV  = 3;
    localparam int COUNT_DIV = 9;
    localparam int MAXV      = 10000;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] value, value_nb;
    logic        wrap, wrap_nb;
    logic [3:0]  digit, digit_nb;
    logic [7:0]  seg_data, seg_nb;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_counter #(.NUM_DIGITS(ND), .SCAN_DIV(SCAN_DIV), .COUNT_DIV(COUNT_DIV), .BLANK_LEADING(1)) dut (
        .clk(clk), .rstb(rstb), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
        .value(value), .wrap(wrap), .digit(digit), .seg_data(seg_data)
    );

    seg_scan_counter #(.NUM_DIGITS(ND), .SCAN_DIV(SCAN_DIV), .COUNT_DIV(COUNT_DIV), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .rstb(rstb), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
        .value(value_nb), .wrap(wrap_nb), .digit(digit_nb), .seg_data(seg_nb)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] pat(input int d);
        case (d)
            0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
            4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
            8: return 8'h7F;  9: return 8'h6F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int pos, input bit blank);
        if (blank && pos != 0 && v < 10 ** pos) return 8'h00;
        return pat((v / (10 ** pos)) % 10);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
        return r;
    endfunction

    function automatic int sat_val(input logic [15:0] lv);
        int s = 0;
        for (int k = 0; k < ND; k++) begin
            int n = int'(lv[4*k +: 4]);
            s += ((n > 9) ? 9 : n) * (10 ** k);
        end
        return s;
    endfunction

    int         m_val, m_cpre, m_spre, m_sidx, nidx;
    bit         m_wrap;
    logic [3:0] m_digit;
    logic [7:0] m_seg, m_seg_nb;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_val <= 0; m_wrap <= 1'b0; m_cpre <= 0; m_spre <= 0; m_sidx <= 0;
            m_digit <= 4'b1000; m_seg <= 8'h00; m_seg_nb <= 8'h3F;
        end else begin
            if (clr) begin
                m_val <= 0; m_wrap <= 1'b0; m_cpre <= 0;
            end else begin
                m_cpre <= (m_cpre == COUNT_DIV) ? 0 : m_cpre + 1;
                if (load) begin
                    m_val <= sat_val(load_val); m_wrap <= 1'b0;
                end else if (m_cpre == COUNT_DIV && en) begin
                    if (up) begin m_val <= (m_val + 1) % MAXV;        m_wrap <= (m_val == MAXV - 1); end
                    else    begin m_val <= (m_val + MAXV - 1) % MAXV; m_wrap <= (m_val == 0);        end
                end else begin
                    m_wrap <= 1'b0;
                end
            end
            if (m_spre == SCAN_DIV) begin
                nidx = (m_sidx + 1) % ND;
                m_spre <= 0; m_sidx <= nidx;
                m_digit  <= 4'(1 << (ND - 1 - nidx));
                m_seg    <= exp_seg(m_val, ND - 1 - nidx, 1'b1);
                m_seg_nb <= exp_seg(m_val, ND - 1 - nidx, 1'b0);
            end else begin
                m_spre <= m_spre + 1;
            end
        end
    end

    // {value, wrap, digit, seg} of both instances against the model
    function automatic logic [56:0] got_vec();
        return {value, wrap, digit, seg_data, value_nb, digit_nb, seg_nb};
    endfunction
    function automatic logic [56:0] exp_vec();
        return {to_bcd(m_val), m_wrap, m_digit, m_seg, to_bcd(m_val), m_digit, m_seg_nb};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rstb = 1'b0; en = 1'b1; up = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({value, wrap, digit, seg_data, seg_nb} !== {16'h0000, 1'b0, 4'b1000, 8'h00, 8'h3F}) begin
            n_err++;
            $display("FAIL reset: got %h/%b/%b/%h/%h want 0000/0/1000/00/3f", value, wrap, digit, seg_data, seg_nb);
        end
        rstb = 1'b1;
    endtask

    task automatic test_count_up();
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL count_up cyc%0d: got %h want %h", i, got_vec(), exp_vec());
            end
            if (i == 10 || i == 20) begin
                n_cmp++;
                if (value !== to_bcd(i / 10)) begin
                    n_err++; $display("FAIL count_up_step cyc%0d: got %h want %h", i, value, to_bcd(i / 10));
                end
            end
        end
    endtask

    task automatic test_wrap();
        int nw;
        up = 1'b1; en = 1'b1; load = 1'b1; load_val = 16'h9999;
        nw = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            load = 1'b0;
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL wrap_up cyc%0d: got %h want %h", i, got_vec(), exp_vec());
            end
            if (wrap === 1'b1) nw++;
        end
        n_cmp++;
        if (nw != 1) begin n_err++; $display("FAIL wrap_up_pulses: got %0d want 1", nw); end
        up = 1'b0; clr = 1'b1;
        nw = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            clr = 1'b0;
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL wrap_down cyc%0d: got %h want %h", i, got_vec(), exp_vec());
            end
            if (wrap === 1'b1) nw++;
        end
        n_cmp++;
        if (nw != 1 || value !== 16'h9999) begin
            n_err++; $display("FAIL wrap_down_end: got pulses=%0d value=%h want 1/9999", nw, value);
        end
    endtask

    task automatic test_carry();
        bit seen;
        up = 1'b1; en = 1'b1; load = 1'b1; load_val = 16'h0109;
        @(negedge clk);
        load = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL carry cyc%0d: got %h want %h", i, got_vec(), exp_vec());
            end
            if (value !== 16'h0109) seen = 1'b1;
        end
        en = 1'b0;
        n_cmp++;
        if (value !== 16'h0110) begin n_err++; $display("FAIL carry_value: got %h want 0110", value); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL carry_scan cyc%0d: got %h want %h", i, got_vec(), exp_vec());
            end
            if (i >= 4 && m_digit == 4'b1000) begin
                n_cmp++;
                if (seg_data !== 8'h00) begin n_err++; $display("FAIL carry_blank: got %h want 00", seg_data); end
            end
        end
    endtask

    task automatic test_sat_clr();
        en = 1'b0; load = 1'b1; load_val = 16'h3AF5;
        @(negedge clk);
        load = 1'b0;
        n_cmp++;
        if (value !== 16'h3995) begin n_err++; $display("FAIL saturate: got %h want 3995", value); end
        en = 1'b1; up = 1'b1; clr = 1'b1; load = 1'b1; load_val = 16'h1234;
        @(negedge clk);
        clr = 1'b0; load = 1'b0;
        n_cmp++;
        if (value !== 16'h0000) begin n_err++; $display("FAIL clr_over_load: got %h want 0000", value); end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (value !== ((i == 10) ? 16'h0001 : 16'h0000) || got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL clr_restart cyc%0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_hold();
        logic [15:0] held;
        en = 1'b0;
        held = to_bcd(m_val);
        for (int i = 0; i < 55; i++) begin
            up = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if (got_vec() !== exp_vec() || value !== held || wrap !== 1'b0) begin
                n_err++; $display("FAIL hold cyc%0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 7) != 0);
            up   = 1'($urandom);
            clr  = ($urandom_range(0, 40) == 0);
            load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 16'h9999;
                1:       load_val = 16'h0000;
                default: load_val = 16'($urandom);
            endcase
            @(negedge clk);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random cyc%0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        clr = 1'b0; load = 1'b0;
    endtask

    task automatic test_noblank();
        en = 1'b0; load = 1'b1; load_val = 16'h0042;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL noblank cyc%0d: got %h want %h", i, got_vec(), exp_vec());
            end
            if (i >= 4 && m_digit == 4'b0010) begin
                n_cmp++;
                if (seg_nb !== 8'h66 || seg_data !== 8'h66) begin
                    n_err++; $display("FAIL noblank_four: got %h/%h want 66/66", seg_nb, seg_data);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; load = 1'b1; load_val = 16'h5678;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        n_cmp++;
        if ({value, wrap, digit, seg_data} !== {16'h0000, 1'b0, 4'b1000, 8'h00}) begin
            n_err++; $display("FAIL async_reset: got %h/%b/%b/%h want 0000/0/1000/00", value, wrap, digit, seg_data);
        end
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL after_reset cyc%0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_carry();
        test_sat_clr();
        test_hold();
        test_random();
        test_noblank();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
